// File: rtl/quad_encoder_counter_if.sv
// Encoder-side bus of quad_encoder_counter: control inputs, raw phases and
// the decoded position/status outputs. The clock and reset stay plain ports.
interface quad_encoder_counter_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             rotA;
    logic             rotB;
    logic [CNT_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;

    // Master drives the controls and the encoder pins and observes the position.
    modport master (output en, clr, rotA, rotB, input pos, dir, step, err);
    // Slave is the decoder itself.
    modport slave  (input en, clr, rotA, rotB, output pos, dir, step, err);
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature rotary-encoder decoder with a bounded detent counter.
// The raw phases are synchronised, glitch-filtered and decoded. Valid moves
// accumulate in a signed sub-detent counter. Each full detent steps pos up
// or down, either saturating or wrapping at the configured limits.
module quad_encoder_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CPD         = 4,
    parameter int WRAP        = 0,
    parameter int CNT_MIN     = 0,
    parameter int CNT_MAX     = 255,
    parameter int POS_INIT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_encoder_counter_if.slave  bus
);

    // Phase pair state, written {A,B}.
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q10 = 2'b10,
        Q11 = 2'b11
    } quad_t;

    localparam int SUB_W = 4;  // holds -4..+4 for every legal CPD
    localparam int FCW   = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]        MIN_V   = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0]        MAX_V   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]        INIT_V  = CNT_W'(POS_INIT);
    localparam logic signed [SUB_W-1:0] SUB_TOP = SUB_W'(CPD);
    localparam logic signed [SUB_W-1:0] SUB_BOT = -SUB_TOP;

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  synced;
    logic [1:0]                  filt;

    quad_t                   state_q, state_d, cur;
    logic signed [SUB_W-1:0] sub_q, sub_d, sub_sum, move;
    logic [CNT_W-1:0]        pos_q, pos_d, pos_up, pos_dn;
    logic                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    err_q, err_d;
    logic                    illegal;

    // Shift both raw phases through the synchroniser chain.
    // NOTE: flops use non-blocking (<=) so all stages update from pre-edge values.
    // NOTE: every synchroniser stage is reset, because the reset state of the whole decode path is defined as 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.rotA, bus.rotB}};
        end else begin
            sync_q <= {bus.rotA, bus.rotB};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_CYCLES == 0) begin : g_nofilt
            assign filt = synced;
        end else begin : g_filt
            localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_CYCLES - 1);
            for (genvar p = 0; p < 2; p++) begin : g_phase
                logic [FCW-1:0] cnt_q;
                logic           filt_q;

                // Accept a new level only after FILT_CYCLES consecutive disagreeing cycles.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt_q  <= '0;
                        filt_q <= 1'b0;
                    end else if (synced[p] == filt_q) begin
                        cnt_q  <= '0;
                    end else if (cnt_q == FILT_LAST) begin
                        cnt_q  <= '0;
                        filt_q <= synced[p];
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end

                assign filt[p] = filt_q;
            end
        end
    endgenerate

    assign cur = quad_t'(filt);

    // Classify the previous -> current phase pair as CW, CCW, idle or illegal.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        move    = '0;
        illegal = 1'b0;
        case ({state_q, cur})
            {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: move = SUB_W'(1);
            {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: move = -SUB_W'(1);
            {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: illegal = 1'b1;
            default: ;
        endcase
    end

    // Bounded +/-1. The limit is checked before the increment, so the counter never overflows.
    assign pos_up  = (pos_q >= MAX_V) ? ((WRAP != 0) ? MIN_V : pos_q) : pos_q + 1'b1;
    assign pos_dn  = (pos_q <= MIN_V) ? ((WRAP != 0) ? MAX_V : pos_q) : pos_q - 1'b1;
    assign sub_sum = sub_q + move;

    // Next-state logic: accumulate moves, complete detents, and apply clr over everything but the step.
    always_comb begin
        state_d = cur;
        sub_d   = sub_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        if (bus.en) begin
            if (illegal) begin
                err_d = 1'b1;
                sub_d = '0;
            end else if (move != '0) begin
                if (sub_sum == SUB_TOP) begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    sub_d  = '0;
                    pos_d  = pos_up;
                end else if (sub_sum == SUB_BOT) begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    sub_d  = '0;
                    pos_d  = pos_dn;
                end else begin
                    sub_d  = sub_sum;
                end
            end
        end
        if (bus.clr) begin
            pos_d = INIT_V;
            sub_d = '0;
            err_d = 1'b0;
        end
    end

    // Register the decode state, the accumulator and the visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q00;
            sub_q   <= '0;
            pos_q   <= INIT_V;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign bus.pos  = pos_q;
    assign bus.dir  = dir_q;
    assign bus.step = step_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter. Six instances cover the default,
// offset-init, saturate, wrap, unfiltered and one-count-per-detent builds.
// Every expected step is queued before the stimulus that should cause it.
// A negedge monitor pops the queue and checks each step pulse.
module tb_quad_encoder_counter;

    localparam int ND = 6;

    typedef struct {
        int         dut;
        logic       dir;
        logic [7:0] pos;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [ND-1:0]      en_v  = '1;
    logic [ND-1:0]      clr_v = '0;
    logic [ND-1:0]      ra    = '0;
    logic [ND-1:0]      rb    = '0;
    logic [ND-1:0]      step_w, dir_w, err_w;
    logic [ND-1:0][7:0] pos_w;

    exp_t sb_q[$];
    int   step_cnt [ND];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    quad_encoder_counter_if #(.CNT_W(8)) bus [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_conn
        assign bus[g].en   = en_v[g];
        assign bus[g].clr  = clr_v[g];
        assign bus[g].rotA = ra[g];
        assign bus[g].rotB = rb[g];
        assign pos_w[g]    = bus[g].pos;
        assign dir_w[g]    = bus[g].dir;
        assign step_w[g]   = bus[g].step;
        assign err_w[g]    = bus[g].err;
    end

    quad_encoder_counter u_def  (.clk(clk), .rst(rst), .bus(bus[0]));
    quad_encoder_counter #(.POS_INIT(128))
                         u_init (.clk(clk), .rst(rst), .bus(bus[1]));
    quad_encoder_counter #(.CNT_MAX(7), .WRAP(0))
                         u_sat  (.clk(clk), .rst(rst), .bus(bus[2]));
    quad_encoder_counter #(.CNT_MAX(7), .WRAP(1))
                         u_wrap (.clk(clk), .rst(rst), .bus(bus[3]));
    quad_encoder_counter #(.FILT_CYCLES(0))
                         u_nof  (.clk(clk), .rst(rst), .bus(bus[4]));
    quad_encoder_counter #(.CPD(1))
                         u_cpd1 (.clk(clk), .rst(rst), .bus(bus[5]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic a, input logic b, input int hold);
        ra[d] = a;
        rb[d] = b;
        repeat (hold) tick();
    endtask

    task automatic cw(input int d, input int hold);
        drive(d, 1'b1, 1'b0, hold);
        drive(d, 1'b1, 1'b1, hold);
        drive(d, 1'b0, 1'b1, hold);
        drive(d, 1'b0, 1'b0, hold);
    endtask

    task automatic ccw(input int d, input int hold);
        drive(d, 1'b0, 1'b1, hold);
        drive(d, 1'b1, 1'b1, hold);
        drive(d, 1'b1, 1'b0, hold);
        drive(d, 1'b0, 1'b0, hold);
    endtask

    task automatic push(input int d, input logic dir, input logic [7:0] pos);
        exp_t e;
        e.dut = d;
        e.dir = dir;
        e.pos = pos;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every step pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < ND; i++) begin
                if (step_w[i]) begin
                    step_cnt[i]++;
                    check("step_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_dut", 32'(i), 32'(e.dut));
                        check("sb_pos", 32'(pos_w[i]), 32'(e.pos));
                        check("sb_dir", 32'(dir_w[i]), 32'(e.dir));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < ND; i++) step_cnt[i] = 0;

        // Reset state
        tick();
        tick();
        check("rst_pos", 32'(pos_w[0]), 32'd0);
        check("rst_dir", 32'(dir_w[0]), 32'd0);
        check("rst_step", 32'(step_w[0]), 32'd0);
        check("rst_err", 32'(err_w[0]), 32'd0);
        check("rst_pos_init128", 32'(pos_w[1]), 32'd128);
        rst = 1'b0;
        tick();

        // 1: first CW detent with latency measurement, then reset mid-rotation
        push(0, 1'b1, 8'd1);
        drive(0, 1'b1, 1'b0, 8);
        drive(0, 1'b1, 1'b1, 8);
        drive(0, 1'b0, 1'b1, 8);
        ra[0] = 1'b0;
        rb[0] = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (step_w[0]) break;
        end
        check("latency_default", 32'(n), 32'd7);
        tick();
        check("cw1_pos", 32'(pos_w[0]), 32'd1);
        check("cw1_dir", 32'(dir_w[0]), 32'd1);

        drive(0, 1'b1, 1'b0, 8);
        drive(0, 1'b1, 1'b1, 3);
        rst = 1'b1;
        #1;
        check("midrst_pos", 32'(pos_w[0]), 32'd0);
        check("midrst_dir", 32'(dir_w[0]), 32'd0);
        check("midrst_step", 32'(step_w[0]), 32'd0);
        check("midrst_err", 32'(err_w[0]), 32'd0);
        ra[0] = 1'b0;
        rb[0] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("postrst_err", 32'(err_w[0]), 32'd0);
        push(0, 1'b1, 8'd1);
        cw(0, 8);
        tick();
        check("postrst_pos", 32'(pos_w[0]), 32'd1);

        // 2: CW/CCW from 128, then clr colliding with a completing detent
        push(1, 1'b1, 8'd129);
        cw(1, 8);
        push(1, 1'b1, 8'd130);
        cw(1, 8);
        push(1, 1'b1, 8'd131);
        cw(1, 8);
        push(1, 1'b0, 8'd130);
        ccw(1, 8);
        tick();
        check("cwccw_pos", 32'(pos_w[1]), 32'd130);
        check("cwccw_steps", 32'(step_cnt[1]), 32'd4);
        drive(1, 1'b1, 1'b0, 8);
        drive(1, 1'b1, 1'b1, 8);
        drive(1, 1'b0, 1'b1, 8);
        ra[1] = 1'b0;
        rb[1] = 1'b0;
        push(1, 1'b1, 8'd128);
        repeat (6) tick();
        clr_v[1] = 1'b1;
        tick();
        clr_v[1] = 1'b0;
        repeat (3) tick();
        check("clr_step_pos", 32'(pos_w[1]), 32'd128);

        // 3: saturate and wrap at CNT_MAX=7
        for (int k = 1; k <= 9; k++) begin
            push(2, 1'b1, (k > 7) ? 8'd7 : 8'(k));
            cw(2, 8);
        end
        for (int k = 1; k <= 9; k++) begin
            push(3, 1'b1, 8'(k % 8));
            cw(3, 8);
        end
        tick();
        check("sat_pos", 32'(pos_w[2]), 32'd7);
        check("sat_steps", 32'(step_cnt[2]), 32'd9);
        check("wrap_pos", 32'(pos_w[3]), 32'd1);
        check("wrap_steps", 32'(step_cnt[3]), 32'd9);
        clr_v[3] = 1'b1;
        tick();
        clr_v[3] = 1'b0;
        check("wrap_clr_pos", 32'(pos_w[3]), 32'd0);
        push(3, 1'b0, 8'd7);
        ccw(3, 8);
        tick();
        check("wrap_under_pos", 32'(pos_w[3]), 32'd7);

        // 4: glitch one cycle shorter than the filter, then unfiltered 1-cycle phases
        ra[0] = 1'b1;
        repeat (3) tick();
        ra[0] = 1'b0;
        repeat (12) tick();
        check("glitch_pos", 32'(pos_w[0]), 32'd1);
        check("glitch_err", 32'(err_w[0]), 32'd0);
        push(0, 1'b1, 8'd2);
        cw(0, 8);
        tick();
        check("postglitch_pos", 32'(pos_w[0]), 32'd2);

        push(4, 1'b1, 8'd1);
        cw(4, 1);
        push(4, 1'b1, 8'd2);
        cw(4, 1);
        push(4, 1'b0, 8'd1);
        ccw(4, 1);
        repeat (6) tick();
        check("nofilt_pos", 32'(pos_w[4]), 32'd1);
        check("nofilt_steps", 32'(step_cnt[4]), 32'd3);

        // en=0: decode tracks the phases but neither counts nor flags errors
        en_v[0] = 1'b0;
        cw(0, 8);
        drive(0, 1'b1, 1'b1, 8);
        drive(0, 1'b0, 0, 8);
        en_v[0] = 1'b1;
        tick();
        check("dis_pos", 32'(pos_w[0]), 32'd2);
        check("dis_err", 32'(err_w[0]), 32'd0);
        push(0, 1'b1, 8'd3);
        cw(0, 8);
        tick();
        check("reen_pos", 32'(pos_w[0]), 32'd3);

        // 5: both phases change together, then clr
        drive(0, 1'b1, 1'b1, 8);
        drive(0, 1'b0, 1'b0, 8);
        check("illegal_err", 32'(err_w[0]), 32'd1);
        check("illegal_pos", 32'(pos_w[0]), 32'd3);
        clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        check("clr_err", 32'(err_w[0]), 32'd0);
        check("clr_pos", 32'(pos_w[0]), 32'd0);

        // 6: reversal mid-detent, then the same walk with one count per detent
        drive(0, 1'b1, 1'b0, 8);
        drive(0, 1'b1, 1'b1, 8);
        drive(0, 1'b1, 1'b0, 8);
        drive(0, 1'b0, 1'b0, 8);
        tick();
        check("rev_pos", 32'(pos_w[0]), 32'd0);
        check("rev_err", 32'(err_w[0]), 32'd0);

        push(5, 1'b1, 8'd1);
        push(5, 1'b1, 8'd2);
        push(5, 1'b0, 8'd1);
        push(5, 1'b0, 8'd0);
        drive(5, 1'b1, 1'b0, 8);
        drive(5, 1'b1, 1'b1, 8);
        drive(5, 1'b1, 1'b0, 8);
        drive(5, 1'b0, 1'b0, 8);
        tick();
        check("cpd1_pos", 32'(pos_w[5]), 32'd0);
        check("cpd1_steps", 32'(step_cnt[5]), 32'd4);

        repeat (4) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
